// File: rtl/mult_booth.sv
// mult_booth: sequential 32x32 signed radix-2 Booth multiplier.
// One recode step per clock; low 32 product bits plus overflow flag.
module mult_booth (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [32:0] r_m;
  logic [32:0] r_acc;
  logic [31:0] r_q;
  logic        r_q1;
  logic [5:0]  r_cnt;

  logic [32:0] w_sum;
  logic [32:0] w_acc_n;
  logic [31:0] w_q_n;
  logic [32:0] w_hi;
  logic        w_exc;

  // Booth recode of {Q[0],q_1}, then arithmetic right shift of {ACC,Q,q_1}.
  always_comb begin
    w_sum = r_acc;
    unique case ({r_q[0], r_q1})
      2'b01:   w_sum = r_acc + r_m;
      2'b10:   w_sum = r_acc - r_m;
      default: w_sum = r_acc;
    endcase
    w_acc_n = {w_sum[32], w_sum[32:1]};
    w_q_n   = {w_sum[0], r_q[31:1]};
    // Product fits in 32 bits only if bits 63..31 are all sign copies.
    w_hi    = {w_acc_n[31:0], w_q_n[31]};
    w_exc   = !((&w_hi) || (~|w_hi));
  end

  // Control FSM, datapath and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_m            <= '0;
      r_acc          <= '0;
      r_q            <= '0;
      r_q1           <= 1'b0;
      r_cnt          <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else if (ctrl_MULT) begin
      r_state        <= BUSY;
      r_m            <= {data_operandA[31], data_operandA};
      r_acc          <= '0;
      r_q            <= data_operandB;
      r_q1           <= 1'b0;
      r_cnt          <= '0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      unique case (r_state)
        BUSY: begin
          r_acc <= w_acc_n;
          r_q   <= w_q_n;
          r_q1  <= r_q[0];
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) begin
            r_state        <= DONE;
            data_result    <= w_q_n;
            data_exception <= w_exc;
            data_resultRDY <= 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_booth.sv
// tb_mult_booth: directed vector table plus abort/restart/reset sequences.
// Expected values are hand-computed products.
module tb_mult_booth;

  logic        clock;
  logic        reset_n;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int errors = 0;
  int checks = 0;

  mult_booth dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
  endtask

  // Watch up to 40 edges; report first strobe edge index and strobe count.
  task automatic watch(input int base, output int lat, output int nstb);
    lat = -1;
    nstb = 0;
    for (int i = base + 1; i <= base + 40; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        nstb++;
        if (lat < 0) lat = i;
      end
    end
  endtask

  initial begin
    int lat;
    int nstb;
    int pre;
    logic [31:0] prev;

    vecs[0] = '{32'd3, 32'd5, 32'h0000000F, 1'b0};
    vecs[1] = '{32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFD6, 1'b0};
    vecs[2] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[3] = '{32'h00010000, 32'h00010000, 32'h00000000, 1'b1};
    vecs[4] = '{32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 1'b0};

    reset_n = 1'b0;
    ctrl_MULT = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_result", data_result, 32'h0);
    chk("reset_exc", {31'b0, data_exception}, 32'h0);
    chk("reset_rdy", {31'b0, data_resultRDY}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    prev = 32'h0;
    for (int k = 0; k < 5; k++) begin
      start(vecs[k].a, vecs[k].b);
      repeat (5) begin
        @(posedge clock);
        #1;
      end
      chk($sformatf("hold_v%0d", k), data_result, prev);
      watch(5, lat, nstb);
      chk($sformatf("lat_v%0d", k), lat, 32);
      chk($sformatf("nstb_v%0d", k), nstb, 1);
      chk($sformatf("res_v%0d", k), data_result, vecs[k].res);
      chk($sformatf("exc_v%0d", k), {31'b0, data_exception},
          {31'b0, vecs[k].exc});
      prev = vecs[k].res;
    end

    // Restart while busy: 9x9 aborted at step 10 by 4 x -4.
    start(32'd9, 32'd9);
    pre = 0;
    repeat (9) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) pre++;
    end
    start(32'd4, 32'hFFFFFFFC);
    watch(0, lat, nstb);
    chk("abort_lat", lat, 32);
    chk("abort_nstb", nstb + pre, 1);
    chk("abort_res", data_result, 32'hFFFFFFF0);
    chk("abort_exc", {31'b0, data_exception}, 32'h0);

    // Back-to-back: new start sampled on the edge leaving DONE.
    start(32'd2, 32'd2);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        lat = i;
        break;
      end
    end
    chk("b2b_first_lat", lat, 32);
    chk("b2b_first_res", data_result, 32'h4);
    data_operandA = 32'd7;
    data_operandB = 32'hFFFFFFFF;
    ctrl_MULT = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    chk("b2b_no_repeat", {31'b0, data_resultRDY}, 32'h0);
    watch(0, lat, nstb);
    chk("b2b_lat", lat, 32);
    chk("b2b_nstb", nstb, 1);
    chk("b2b_res", data_result, 32'hFFFFFFF9);

    // Reset mid-operation aborts with no strobe.
    start(32'd9, 32'd9);
    repeat (19) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_result", data_result, 32'h0);
    chk("rst_mid_exc", {31'b0, data_exception}, 32'h0);
    chk("rst_mid_rdy", {31'b0, data_resultRDY}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    watch(0, lat, nstb);
    chk("rst_mid_nstb", nstb, 0);
    chk("rst_mid_result_after", data_result, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_booth.md
# mult_booth

Sequential 32×32 signed multiplier using radix-2 Booth recoding, one recode step per clock. It is the multiply counterpart to the team's iterative divider in the multdiv unit and uses the same operand/control/result handshake, so the pipeline's multdiv stall logic can drive either block identically. It produces the low 32 bits of the signed product and flags results that do not fit in 32 bits.

## Interface
- No parameters; width fixed at 32.
- clock  input  1  rising-edge clock for all state.
- reset_n  input  1  asynchronous, active-low reset.
- data_operandA  input  32  multiplicand, two's complement; sampled only on a ctrl_MULT edge.
- data_operandB  input  32  multiplier, two's complement; sampled only on a ctrl_MULT edge.
- ctrl_MULT  input  1  start pulse; 1 on a rising edge starts a new multiply.
- data_result  output  32  low 32 bits of A×B; registered.
- data_exception  output  1  1 when the 64-bit product is not representable as signed 32-bit; registered.
- data_resultRDY  output  1  one-cycle completion strobe.

## Operation
- Datapath registers:
  - M: 33-bit sign-extended multiplicand.
  - ACC: 33-bit accumulator, the high part.
  - Q: 32-bit multiplier/low product.
  - q_1: Booth extra bit.
  - 6-bit iteration counter.
- ACC is 33 bits so that ACC±M cannot overflow, including for operand 0x80000000.
- States: IDLE, BUSY, DONE.
- Start: ctrl_MULT=1 at an edge, in any state.
  - Loads M={A[31],A}, ACC=0, Q=B, q_1=0, count=0.
  - State goes to BUSY.
- BUSY step, once per edge:
  - Recode {Q[0],q_1}: 01 means ACC+=M; 10 means ACC-=M; 00 and 11 mean no add.
  - Then arithmetic-shift {ACC,Q,q_1} right by 1, replicating ACC[32].
  - count increments.
  - The step with count==31 is the 32nd. After it the state goes to DONE, and data_result and data_exception are registered.
- data_result = Q after the 32nd step.
- data_exception = 1 unless ACC[31:0] and Q[31] after the 32nd step are all equal bits, i.e. the upper 33 product bits are a pure sign extension.
- DONE lasts one cycle with data_resultRDY=1, then the state goes to IDLE.
- data_result and data_exception hold their values until the next completion or reset. They do not change during a following BUSY period.
- Operand changes while BUSY have no effect.

## Timing
- Reset (reset_n=0, asynchronous): state IDLE, all registers 0, data_result=0, data_exception=0, data_resultRDY=0. Reset mid-operation aborts the operation and produces no strobe.
- Latency: ctrl_MULT sampled at edge E0; steps occur at E1..E32; data_resultRDY is 1 from E32 to E33 and 0 after E33. Result is ready 32 cycles after the start edge.
- Back-to-back starts:
  - ctrl_MULT at E33, while the state is leaving DONE, is legal.
  - ctrl_MULT in the DONE cycle, sampled at E33, starts the new operation.
  - The strobe already issued is not repeated.
- Restart while BUSY: ctrl_MULT discards the in-flight operation, reloads from the current operands, and restarts the 32-cycle count. No strobe is issued for the aborted operation.
- ctrl_MULT held high for several cycles restarts on every edge; the result arrives 32 cycles after the last high edge.
- data_resultRDY is never asserted for two consecutive cycles.

## Test plan
- 3×5 → 32 cycles after start: data_result=0x0000000F, data_exception=0, data_resultRDY high exactly one cycle.
- −7×6 (0xFFFFFFF9, 0x00000006) → data_result=0xFFFFFFD6, data_exception=0.
- 0x80000000×0xFFFFFFFF → data_result=0x80000000, data_exception=1.
- 0x00010000×0x00010000 → data_result=0x00000000, data_exception=1.
- 0x7FFFFFFF×1 → data_result=0x7FFFFFFF, data_exception=0.
- Abort and restart:
  - Start 9×9, then pulse ctrl_MULT at step 10 with 4×−4 → single strobe 32 cycles after the second pulse, data_result=0xFFFFFFF0, data_exception=0.
  - Start 9×9, then drop reset_n at step 20 → outputs go to 0 and no strobe follows.
